// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: run-controller bus (req/prog_sel/fetch/branch in, PC/status/cycle count out)
interface core_run_ctrl_if #(parameter int D = 12, I = 9, C = 16, SW = 2);
  logic          req;
  logic [SW-1:0] prog_sel;
  logic [I-1:0]  instr;
  logic          branch_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [C-1:0]  cycles;
  modport master (output req, prog_sel, instr, branch_en, target,
                  input prog_ctr, core_en, busy, done, timeout, cycles);
  modport slave (input req, prog_sel, instr, branch_en, target,
                 output prog_ctr, core_en, busy, done, timeout, cycles);
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: PC sequencer with req/done handshake, halt detect, cycle count and watchdog (clk, reset, bus)
module core_run_ctrl #(parameter int D = 12, I = 9, P = 4, S = 8, C = 16, WD = 0) (
  input logic clk,
  input logic reset,
  core_run_ctrl_if.slave bus
);
  localparam int SW = (P > 1) ? $clog2(P) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [D-1:0] pc_q, pc_n, entry;
  logic [C-1:0] cyc_q, cyc_n;
  logic to_q, to_n, halt, wd_hit, exec;
  logic [SW-1:0] sel;
  assign sel = (int'(bus.prog_sel) < P) ? bus.prog_sel : '0;
  assign entry = D'(sel) << S;
  assign halt = bus.instr == '0;
  assign wd_hit = (WD != 0) && (cyc_q == C'(WD));
  assign exec = state == RUN && bus.req && !halt && !wd_hit;
  always_comb begin
    state_n = state;
    pc_n = pc_q;
    cyc_n = cyc_q;
    to_n = to_q;
    case (state)
      IDLE: if (bus.req) begin
        state_n = RUN;
        pc_n = entry;
        cyc_n = '0;
        to_n = 1'b0;
      end
      RUN: if (!bus.req) state_n = IDLE;
      else if (halt) state_n = DONE;
      else if (wd_hit) begin
        state_n = DONE;
        to_n = 1'b1;
      end else begin
        pc_n = bus.branch_en ? bus.target : pc_q + 1'b1;
        cyc_n = &cyc_q ? cyc_q : cyc_q + 1'b1;
      end
      DONE: if (!bus.req) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_q <= '0;
      cyc_q <= '0;
      to_q <= 1'b0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      cyc_q <= cyc_n;
      to_q <= to_n;
    end
  end
  assign bus.prog_ctr = pc_q;
  assign bus.cycles = cyc_q;
  assign bus.timeout = to_q;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.core_en = exec;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: vector table + scoreboard bench over three controller configurations
module tb_core_run_ctrl;
  typedef struct {
    int id;
    int idx;
    bit rst;
    bit req;
    logic [1:0] sel;
    logic [8:0] ins;
    bit br;
    logic [11:0] tgt;
    logic [11:0] pc;
    bit ce;
    bit bsy;
    bit dn;
    bit to;
    logic [15:0] cyc;
  } vec_t;
  localparam logic [8:0] N = 9'h001;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  vec_t tv[$];
  vec_t sb[$];
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  core_run_ctrl_if #(.D(12), .I(9), .C(16), .SW(2)) b0 ();
  core_run_ctrl_if #(.D(12), .I(9), .C(16), .SW(2)) b1 ();
  core_run_ctrl_if #(.D(4), .I(9), .C(3), .SW(2)) b2 ();
  core_run_ctrl #(.D(12), .I(9), .P(4), .S(8), .C(16), .WD(0)) u0 (.clk(clk), .reset(rst0), .bus(b0));
  core_run_ctrl #(.D(12), .I(9), .P(4), .S(8), .C(16), .WD(5)) u1 (.clk(clk), .reset(rst1), .bus(b1));
  core_run_ctrl #(.D(4), .I(9), .P(3), .S(2), .C(3), .WD(0)) u2 (.clk(clk), .reset(rst2), .bus(b2));
  task automatic t(input int id, input bit rst, req, input logic [1:0] sel, input logic [8:0] ins,
                   input bit br, input logic [11:0] tgt, pc, input bit ce, bsy, dn, to, input logic [15:0] cyc);
    vec_t v;
    v.id = id; v.idx = tv.size(); v.rst = rst; v.req = req; v.sel = sel; v.ins = ins; v.br = br;
    v.tgt = tgt; v.pc = pc; v.ce = ce; v.bsy = bsy; v.dn = dn; v.to = to; v.cyc = cyc;
    tv.push_back(v);
  endtask
  task automatic drive(input vec_t v);
    case (v.id)
      0: begin rst0 = v.rst; b0.req = v.req; b0.prog_sel = v.sel; b0.instr = v.ins; b0.branch_en = v.br; b0.target = v.tgt; end
      1: begin rst1 = v.rst; b1.req = v.req; b1.prog_sel = v.sel; b1.instr = v.ins; b1.branch_en = v.br; b1.target = v.tgt; end
      default: begin rst2 = v.rst; b2.req = v.req; b2.prog_sel = v.sel; b2.instr = v.ins; b2.branch_en = v.br; b2.target = v.tgt[3:0]; end
    endcase
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      logic [31:0] act, exp_v;
      e = sb.pop_front();
      case (e.id)
        0: act = {b0.prog_ctr, b0.core_en, b0.busy, b0.done, b0.timeout, b0.cycles};
        1: act = {b1.prog_ctr, b1.core_en, b1.busy, b1.done, b1.timeout, b1.cycles};
        default: act = {8'h0, b2.prog_ctr, b2.core_en, b2.busy, b2.done, b2.timeout, 13'h0, b2.cycles};
      endcase
      exp_v = {e.pc, e.ce, e.bsy, e.dn, e.to, e.cyc};
      checks++;
      if (act === exp_v) passed++;
      else $display("FAIL row%0d dut%0d {pc,ce,busy,done,to,cyc}: got pc=%h flags=%b cyc=%h, want pc=%h flags=%b cyc=%h",
                    e.idx, e.id, act[31:20], act[19:16], act[15:0], exp_v[31:20], exp_v[19:16], exp_v[15:0]);
    end
  end
  initial begin
    rst0 = 1; rst1 = 1; rst2 = 1;
    b0.req = 0; b0.prog_sel = 0; b0.instr = N; b0.branch_en = 0; b0.target = 0;
    b1.req = 0; b1.prog_sel = 0; b1.instr = N; b1.branch_en = 0; b1.target = 0;
    b2.req = 0; b2.prog_sel = 0; b2.instr = N; b2.branch_en = 0; b2.target = 0;
    t(0,0,0,0,N,0,0, 12'h000,0,0,0,0,0);
    t(0,0,1,2,N,0,0, 12'h000,0,0,0,0,0);
    for (int k = 0; k < 3; k++) t(0,0,1,0,N,0,0, 12'h200 + 12'(k),1,1,0,0,16'(k));
    t(0,0,1,0,0,0,0, 12'h203,0,1,0,0,3);
    for (int k = 0; k < 10; k++) t(0,0,1,0,9'h0A5,1,12'h777, 12'h203,0,0,1,0,3);
    t(0,0,0,0,N,0,0, 12'h203,0,0,1,0,3);
    t(0,0,0,0,N,0,0, 12'h203,0,0,0,0,3);
    t(0,0,1,0,N,0,0, 12'h203,0,0,0,0,3);
    t(0,0,1,0,N,0,0, 12'h000,1,1,0,0,0);
    t(0,0,1,0,N,1,12'h050, 12'h001,1,1,0,0,1);
    t(0,0,1,0,0,1,12'h999, 12'h050,0,1,0,0,2);
    t(0,0,0,0,N,0,0, 12'h050,0,0,1,0,2);
    t(0,0,0,0,N,0,0, 12'h050,0,0,0,0,2);
    t(0,0,1,1,N,0,0, 12'h050,0,0,0,0,2);
    t(0,0,1,0,N,0,0, 12'h100,1,1,0,0,0);
    t(0,0,1,0,N,0,0, 12'h101,1,1,0,0,1);
    t(0,0,0,0,N,1,12'h3AB, 12'h102,0,1,0,0,2);
    t(0,0,0,0,N,0,0, 12'h102,0,0,0,0,2);
    t(0,0,1,3,N,0,0, 12'h102,0,0,0,0,2);
    t(0,0,1,0,N,0,0, 12'h300,1,1,0,0,0);
    t(0,0,0,0,0,0,0, 12'h301,0,1,0,0,1);
    t(0,0,0,0,N,0,0, 12'h301,0,0,0,0,1);
    t(0,0,1,2,N,0,0, 12'h301,0,0,0,0,1);
    t(0,0,1,0,N,0,0, 12'h200,1,1,0,0,0);
    t(0,1,1,0,N,0,0, 12'h201,1,1,0,0,1);
    t(0,0,0,0,N,0,0, 12'h000,0,0,0,0,0);
    t(1,0,0,0,N,0,0, 12'h000,0,0,0,0,0);
    t(1,0,1,0,N,0,0, 12'h000,0,0,0,0,0);
    t(1,0,1,0,N,1,12'h010, 12'h000,1,1,0,0,0);
    for (int k = 1; k < 5; k++) t(1,0,1,0,N,1,12'h010, 12'h010,1,1,0,0,16'(k));
    t(1,0,1,0,N,1,12'h010, 12'h010,0,1,0,0,5);
    t(1,0,1,0,N,0,0, 12'h010,0,0,1,1,5);
    t(1,0,0,0,N,0,0, 12'h010,0,0,1,1,5);
    t(1,0,0,0,N,0,0, 12'h010,0,0,0,1,5);
    t(1,0,1,1,N,0,0, 12'h010,0,0,0,1,5);
    for (int k = 0; k < 5; k++) t(1,0,1,0,N,0,0, 12'h100 + 12'(k),1,1,0,0,16'(k));
    t(1,0,1,0,0,0,0, 12'h105,0,1,0,0,5);
    t(1,0,1,0,N,0,0, 12'h105,0,0,1,0,5);
    t(1,0,0,0,N,0,0, 12'h105,0,0,1,0,5);
    t(1,0,0,0,N,0,0, 12'h105,0,0,0,0,5);
    t(2,0,0,0,N,0,0, 12'h000,0,0,0,0,0);
    t(2,0,1,3,N,0,0, 12'h000,0,0,0,0,0);
    for (int k = 0; k < 9; k++) t(2,0,1,0,N,0,0, 12'(k),1,1,0,0,(k > 7) ? 16'd7 : 16'(k));
    t(2,0,1,0,0,0,0, 12'h009,0,1,0,0,7);
    t(2,0,0,0,N,0,0, 12'h009,0,0,1,0,7);
    t(2,0,0,0,N,0,0, 12'h009,0,0,0,0,7);
    t(2,0,1,1,N,0,0, 12'h009,0,0,0,0,7);
    t(2,0,1,0,N,1,12'h00F, 12'h004,1,1,0,0,0);
    t(2,0,1,0,N,0,0, 12'h00F,1,1,0,0,1);
    t(2,0,1,0,0,0,0, 12'h000,0,1,0,0,2);
    t(2,0,0,0,N,0,0, 12'h000,0,0,1,0,2);
    t(2,0,0,0,N,0,0, 12'h000,0,0,0,0,2);
    repeat (2) @(posedge clk);
    #1;
    rst0 = 0; rst1 = 0; rst2 = 0;
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tv[i]);
      sb.push_back(tv[i]);
    end
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run controller and program sequencer for the single-cycle core: owns the program counter, the external req/done handshake, halt detection, per-run cycle counting and a watchdog. It replaces the free-running PC and the combinational `done` of the current core top level. Program entry is selected from `P` slots, so one instruction ROM can hold several programs. Core state updates are qualified by `core_en`.

## Interface
Parameters:
- `D`, 12, program counter width.
- `I`, 9, instruction width; the all-zero word is HALT.
- `P`, 4, number of program slots, ≥1.
- `S`, 8, log2 of slot stride; entry address of slot k = k << S, truncated to D bits.
- `C`, 16, cycle counter width.
- `WD`, 0, watchdog limit in executed instructions; 0 disables.

Ports (`SW` = max(1, clog2(P))):
- `clk`, in, 1, single clock; all state updates on rising edge.
- `reset`, in, 1, synchronous, active-high.
- `req`, in, 1, run request; level-sensitive four-phase handshake.
- `prog_sel`, in, SW, program slot, sampled when a run starts.
- `instr`, in, I, instruction at `prog_ctr` from instr ROM (combinational ROM).
- `branch_en`, in, 1, taken branch from core datapath.
- `target`, in, D, absolute branch target from PC LUT.
- `prog_ctr`, out, D, current fetch address.
- `core_en`, out, 1, qualifies register-file, memory and carry writes this cycle.
- `busy`, out, 1, high in RUN.
- `done`, out, 1, run complete (halt or timeout).
- `timeout`, out, 1, last run ended by watchdog.
- `cycles`, out, C, instructions executed in the current/last run.

## Operation
- States: IDLE, RUN, DONE. Outputs `busy` = (state==RUN) and `done` = (state==DONE) are decoded from state.
- Reset (synchronous): state IDLE, `prog_ctr`=0, `cycles`=0, `timeout`=0. This gives `busy`=0, `done`=0, `core_en`=0. Reset wins over every other event, including mid-run.
- IDLE, `req`=1:
  - `prog_ctr` ← entry(`prog_sel`); `prog_sel` ≥ P selects slot 0.
  - `cycles` ← 0, `timeout` ← 0, go RUN.
- IDLE, `req`=0: hold all state.
- RUN, evaluated in priority order:
  - (a) `req`=0: abort. Go IDLE; `prog_ctr` and `cycles` hold; `timeout` stays 0; `done` never asserts.
  - (b) `instr`==0: halt. Go DONE; `prog_ctr` holds at the HALT address.
  - (c) WD≠0 and `cycles`==WD: `timeout` ← 1, go DONE, `prog_ctr` holds.
  - (d) Otherwise execute: `prog_ctr` ← `branch_en` ? `target` : `prog_ctr`+1, mod 2^D so 2^D−1 wraps to 0. `cycles` ← `cycles`+1, saturating at 2^C−1.
- `core_en` = state==RUN && `req` && `instr`≠0 && !(WD≠0 && `cycles`==WD). It is combinational and high exactly on case (d) cycles.
- DONE:
  - Hold `prog_ctr`, `cycles`, `timeout`.
  - `req`=1 holds DONE; no restart while `req` stays high.
  - `req`=0 goes IDLE and `done` drops.
- `branch_en` and `target` are ignored outside case (d).

## Timing
- `req` is sampled on the rising edge.
- First instruction executes in the cycle after the edge that samples `req`=1 in IDLE. Start latency is 1 cycle.
- One instruction per cycle. `cycles` equals the number of `core_en`-high cycles in the run.
- `done` rises on the edge that samples HALT, one cycle after the last executed instruction. The HALT cycle has `core_en`=0.
- `done` falls on the edge after `req` is sampled low. A new run needs `req` low for ≥1 cycle in IDLE, then high again.
- With the watchdog enabled, at most WD instructions execute. `done` and `timeout` rise together one cycle after the WD-th instruction.
- Halt and watchdog in the same cycle: halt wins, `timeout`=0.
- Abort and halt in the same cycle: abort wins.

## Test plan
- Reset, then `req`=1, `prog_sel`=2, S=8; ROM straight-line with HALT at 0x203 -> `prog_ctr` 0x200,0x201,0x202,0x203. `done` rises next edge, `cycles`=3, `core_en` high for exactly 3 cycles, `timeout`=0.
- Branch: `branch_en`=1 with `target`=0x050 at PC 0x001 -> next `prog_ctr`=0x050. Also with D=4, PC 0xF non-branch -> next 0x0.
- Watchdog WD=5 on an infinite loop -> exactly 5 `core_en` cycles; `done`=1, `timeout`=1, `cycles`=5. HALT at the 6th fetch gives instead `timeout`=0.
- Handshake: hold `req` high in DONE for 10 cycles -> no restart, state frozen. Drop `req` -> IDLE; re-raise -> new run with `cycles` cleared.
- Abort: drop `req` at the 3rd instruction -> IDLE next edge, `done` never asserts, `core_en`=0 that cycle. Same with `reset` mid-run -> all outputs 0 next edge.
- `prog_sel`=3 with P=3 -> entry 0x000; `cycles` saturation with C=3 over 9 instructions -> `cycles`=7.
